// File: rtl/tlb_pkg.sv
// Shared types for the joint TLB: entry layout, CP0 operation encoding,
// probe/lookup result formats and the common match predicate.
package tlb_pkg;

  localparam int ENTRIES_DEF = 16;
  // Probe index field is sized for the largest supported TLB (64 entries).
  localparam int IDX_MAX = 6;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
  } tlb_entryhi_t;

  typedef struct packed {
    logic               p;
    logic [IDX_MAX-1:0] idx;
  } tlb_index_t;

  typedef struct packed {
    logic        hit;
    logic        v;
    logic        d;
    logic [2:0]  c;
    logic [19:0] pfn;
  } tlb_result_t;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_RESP  = 2'd2
  } tlb_state_e;

  // Global entries ignore the ASID.
  function automatic logic entry_match(tlb_entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational associative search over all entries: per-entry hit vector,
// lowest-index priority encode and even/odd page field select.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int ENTRIES    = ENTRIES_DEF,
  parameter int INDEX_BITS = $clog2(ENTRIES)
) (
  input  tlb_entry_t [ENTRIES-1:0] entries_i,
  input  logic [18:0]              vpn2_i,
  input  logic                     odd_i,
  input  logic [7:0]               asid_i,
  output logic [ENTRIES-1:0]       hit_vec_o,
  output logic                     hit_o,
  output logic [INDEX_BITS-1:0]    idx_o,
  output logic [19:0]              pfn_o,
  output logic [2:0]               c_o,
  output logic                     d_o,
  output logic                     v_o
);

  tlb_entry_t sel;

  // Compare every entry against the tag in parallel.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec_o[i] = entry_match(entries_i[i], vpn2_i, asid_i);
    end
  end

  // Priority encode; scanning downward lets the lowest index win.
  always_comb begin
    hit_o = |hit_vec_o;
    idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec_o[i]) idx_o = INDEX_BITS'(i);
    end
  end

  // Pick the even or odd page of the winning entry; all zero on a miss.
  always_comb begin
    sel   = entries_i[idx_o];
    pfn_o = '0;
    c_o   = '0;
    d_o   = 1'b0;
    v_o   = 1'b0;
    if (hit_o) begin
      if (odd_i) begin
        pfn_o = sel.pfn1;
        c_o   = sel.c1;
        d_o   = sel.d1;
        v_o   = sel.v1;
      end else begin
        pfn_o = sel.pfn0;
        c_o   = sel.c0;
        d_o   = sel.d0;
        v_o   = sel.v0;
      end
    end
  end

endmodule

// File: rtl/tlb_multiport.sv
// Fully associative joint TLB with NUM_PORTS registered lookup ports, a CP0
// operation sequencer (TLBR/TLBWI/TLBWR/TLBP) and the Random counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a CP0 op; reads/writes commit at the accept edge
// ST_PROBE | compare latched EntryHi against all entries, register result
// ST_RESP  | op_done_o pulse, back to ST_IDLE
module tlb_multiport
  import tlb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ENTRIES    = ENTRIES_DEF,
  parameter int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          lk_req_i,
  input  logic [NUM_PORTS-1:0][31:0]    lk_vaddr_i,
  input  logic [7:0]                    asid_i,
  output logic [NUM_PORTS-1:0]          lk_valid_o,
  output tlb_result_t [NUM_PORTS-1:0]   lk_result_o,
  input  logic                          op_valid_i,
  output logic                          op_ready_o,
  input  logic [1:0]                    op_type_i,
  input  logic [INDEX_BITS-1:0]         op_index_i,
  input  tlb_entry_t                    op_wdata_i,
  input  tlb_entryhi_t                  op_entryhi_i,
  output logic                          op_done_o,
  output tlb_entry_t                    op_rdata_o,
  output tlb_index_t                    op_probe_o,
  input  logic [INDEX_BITS:0]           wired_i,
  input  logic                          wired_we_i,
  output logic [INDEX_BITS-1:0]         random_o
);

  localparam int NM = NUM_PORTS + 1;   // last matcher serves TLBP
  localparam logic [INDEX_BITS-1:0] RAND_MAX = INDEX_BITS'(ENTRIES - 1);

  tlb_entry_t [ENTRIES-1:0]  entries_q;
  tlb_state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]      lk_valid_q;
  tlb_result_t [NUM_PORTS-1:0] lk_result_q;
  tlb_entry_t                op_rdata_q;
  tlb_index_t                op_probe_q;
  tlb_entryhi_t              probe_hi_q;
  logic [INDEX_BITS-1:0]     random_q, random_d;

  logic                      wr_en, rd_en, probe_latch, probe_reg;
  logic [INDEX_BITS-1:0]     wr_idx;

  logic [18:0]               m_vpn2  [NM];
  logic                      m_odd   [NM];
  logic [7:0]                m_asid  [NM];
  logic [ENTRIES-1:0]        hit_vec_w [NM];
  logic                      hit_w   [NM];
  logic [INDEX_BITS-1:0]     idx_w   [NM];
  logic [19:0]               pfn_w   [NM];
  logic [2:0]                c_w     [NM];
  logic                      d_w     [NM];
  logic                      v_w     [NM];
  tlb_result_t               port_res [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign m_vpn2[k]   = lk_vaddr_i[k][31:13];
    assign m_odd[k]    = lk_vaddr_i[k][12];
    assign m_asid[k]   = asid_i;
    assign port_res[k] = '{hit: hit_w[k], v: v_w[k], d: d_w[k], c: c_w[k], pfn: pfn_w[k]};
  end

  assign m_vpn2[NUM_PORTS] = probe_hi_q.vpn2;
  assign m_odd[NUM_PORTS]  = 1'b0;
  assign m_asid[NUM_PORTS] = probe_hi_q.asid;

  for (genvar k = 0; k < NM; k++) begin : g_match
    tlb_match #(
      .ENTRIES    (ENTRIES),
      .INDEX_BITS (INDEX_BITS)
    ) u_match (
      .entries_i (entries_q),
      .vpn2_i    (m_vpn2[k]),
      .odd_i     (m_odd[k]),
      .asid_i    (m_asid[k]),
      .hit_vec_o (hit_vec_w[k]),
      .hit_o     (hit_w[k]),
      .idx_o     (idx_w[k]),
      .pfn_o     (pfn_w[k]),
      .c_o       (c_w[k]),
      .d_o       (d_w[k]),
      .v_o       (v_w[k])
    );
  end

  // Lookup pipeline: results come from pre-write entries, zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid_q  <= '0;
      lk_result_q <= '0;
    end else begin
      lk_valid_q <= lk_req_i;
      for (int p = 0; p < NUM_PORTS; p++) begin
        lk_result_q[p] <= lk_req_i[p] ? port_res[p] : '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and per-cycle strobes.
  always_comb begin
    state_d     = state_q;
    op_ready_o  = 1'b0;
    op_done_o   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = op_index_i;
    rd_en       = 1'b0;
    probe_latch = 1'b0;
    probe_reg   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          case (tlb_op_e'(op_type_i))
            OP_TLBR:  begin rd_en = 1'b1; state_d = ST_RESP; end
            OP_TLBWI: begin wr_en = 1'b1; state_d = ST_RESP; end
            OP_TLBWR: begin wr_en = 1'b1; wr_idx = random_q; state_d = ST_RESP; end
            default:  begin probe_latch = 1'b1; state_d = ST_PROBE; end
          endcase
        end
      end
      ST_PROBE: begin
        probe_reg = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        op_done_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry array and CP0 result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q  <= '0;
      op_rdata_q <= '0;
      op_probe_q <= '0;
      probe_hi_q <= '0;
    end else begin
      if (wr_en)       entries_q[wr_idx] <= op_wdata_i;
      if (rd_en)       op_rdata_q <= entries_q[op_index_i];
      if (probe_latch) probe_hi_q <= op_entryhi_i;
      if (probe_reg) begin
        op_probe_q.p   <= ~(|hit_vec_w[NUM_PORTS]);
        op_probe_q.idx <= hit_w[NUM_PORTS] ? IDX_MAX'(idx_w[NUM_PORTS]) : '0;
      end
    end
  end

  // Random next value: reset on Wired write, parked when Wired covers all
  // entries, wraps once it reaches Wired, otherwise counts down.
  always_comb begin
    if (wired_we_i || (wired_i >= (INDEX_BITS+1)'(ENTRIES)) || ({1'b0, random_q} <= wired_i))
      random_d = RAND_MAX;
    else
      random_d = random_q - 1'b1;
  end

  // Random register.
  always_ff @(posedge clk) begin
    if (rst) random_q <= RAND_MAX;
    else     random_q <= random_d;
  end

  assign lk_valid_o  = lk_valid_q;
  assign lk_result_o = lk_result_q;
  assign op_rdata_o  = op_rdata_q;
  assign op_probe_o  = op_probe_q;
  assign random_o    = random_q;

endmodule

// File: doc/tlb_multiport.md
Name: tlb_multiport

Overview:
Parametrised, fully associative MIPS-style joint TLB.
- Serves NUM_PORTS independent translation ports with a registered 1-cycle lookup, for example inst fetch, load/store and page-walk prefetch.
- Executes CP0 TLB operations (TLBR, TLBWI, TLBWR, TLBP) through a valid/ready command interface with a small FSM.
- Owns the Random-register replacement counter bounded by Wired.
- Sits between the MMU front-ends and CP0.

Parameters:
- NUM_PORTS, 2, number of translation lookup ports.
- ENTRIES, 16, number of TLB entries (power of two, 4..64).
- INDEX_BITS, $clog2(ENTRIES), entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- lk_req  in  NUM_PORTS  per-port lookup request
- lk_vaddr  in  NUM_PORTS x 32  per-port virtual address
- asid  in  8  current ASID (EntryHi.ASID)
- lk_valid  out  NUM_PORTS  result valid, 1 cycle after lk_req
- lk_result  out  NUM_PORTS x tlb_result_t  {hit, v, d, c[2:0], pfn[19:0]}
- op_valid  in  1  CP0 op request
- op_ready  out  1  FSM can accept an op
- op_type  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
- op_index  in  INDEX_BITS  index for TLBR/TLBWI
- op_wdata  in  tlb_entry_t  entry for TLBWI/TLBWR
- op_entryhi  in  tlb_entryhi_t  {vpn2, asid} for TLBP
- op_done  out  1  one-cycle completion pulse
- op_rdata  out  tlb_entry_t  TLBR data, valid with op_done
- op_probe  out  tlb_index_t  {p, idx}, valid with op_done for TLBP
- wired  in  INDEX_BITS+1  CP0 Wired value
- wired_we  in  1  Wired register written this cycle
- random  out  INDEX_BITS  current Random value

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All entries are cleared to zero (v=0).
  - lk_valid, lk_result, op_done, op_rdata and op_probe are 0.
  - op_ready is 1, FSM is in IDLE, random is ENTRIES-1.
- Lookup: at edge N the block samples lk_req and lk_vaddr for each port independently.
  - At N+1, lk_valid equals the sampled lk_req.
  - lk_result is zero when the sampled lk_req was 0.
- Match rule: entry.vpn2 == vaddr[31:13] && (entry.g || entry.asid == asid).
  - vaddr[12] selects page 0/1 (pfn, v, d, c). 4 KB pages only.
- Multiple hits: the lowest index wins.
- Miss: hit=0, all other result fields 0.
- Write-vs-lookup at the same edge: the lookup uses pre-write entries. A lookup issued at the edge after the write sees the new entry.
- FSM states:
  - IDLE (op_ready=1): handshake is op_valid && op_ready.
    - TLBR: latch entries[op_index] into op_rdata, then RESP.
    - TLBWI: write op_wdata to entries[op_index] at the accept edge, then RESP.
    - TLBWR: write op_wdata to entries[random] at the accept edge, using the random value at that edge, then RESP.
    - TLBP: latch op_entryhi, then PROBE.
  - PROBE (op_ready=0): compare against all entries using op_entryhi.asid as ASID, register the result into op_probe, then RESP.
    - Hit: p=0, idx = lowest matching index.
    - Miss: p=1, idx=0.
  - RESP (op_ready=0): op_done=1 for exactly this cycle, then IDLE.
  - Latency: TLBR/TLBWI/TLBWR done 1 cycle after accept; TLBP done 2 cycles after accept.
  - op_valid while op_ready=0 is ignored; the requester holds op_valid.
  - op_rdata and op_probe hold their values until the next op of the same type.
- Random counter:
  - Decrements every cycle.
  - When random <= wired, it wraps to ENTRIES-1 instead of decrementing.
  - wired_we forces random to ENTRIES-1 (this takes priority).
  - wired >= ENTRIES holds random at ENTRIES-1.
  - TLBWR does not otherwise perturb the sequence.
- Reset mid-op: rst forces IDLE; no op_done is issued; a pending write is dropped unless it was already committed at an earlier edge.

Decomposition:
- Package tlb_pkg: ENTRIES default, tlb_entry_t {vpn2, asid, g, pfn0/1, c0/1, d0/1, v0/1}, tlb_entryhi_t, tlb_index_t {p, idx}, tlb_result_t, op_type enum.
- Sub-module tlb_match: purely combinational. Inputs are entries, vpn2, odd bit and asid; outputs are a hit vector plus a priority-encoded index and page fields. It is instantiated NUM_PORTS+1 times (ports plus probe).

Test Plan:
- Reset, then lookup port 0 at 0x00402000 with asid=5 -> next cycle lk_valid=1, hit=0, other fields 0; random=ENTRIES-1; op_ready=1.
- TLBWI idx 3 with {vpn2=0x00201, asid=5, g=0, pfn0=0x12345, v0=1, d0=1}, then both ports look up 0x00402000 with asid=5 -> hit=1, pfn=0x12345, d=1. The same lookup with asid=6 -> hit=0.
- TLBWI and a port lookup at the same edge for a new mapping -> that lookup misses; the lookup on the next edge hits.
- TLBP on {vpn2=0x00201, asid=5} with matches at idx 3 and 7 -> op_done 2 cycles after accept, op_probe={p=0, idx=3}. Unmapped vpn2 -> {p=1, idx=0}.
- wired=4, wired_we pulsed -> random reads 15, 14, ..., 4, 15 cycle by cycle. A TLBWR accepted when random=9 writes entry 9, checked via TLBR idx 9.
- Assert rst in PROBE -> no op_done; op_ready=1 the next cycle; all entries read back zero.
